// File: rtl/commit_monitor.sv
// commit_monitor: counts retired instructions, detects self-loop halt and commit watchdog expiry,
// and flags protocol errors. Define COMMIT_MONITOR_MEMCHK_EN to build the memory handshake tracker.
module commit_monitor #(
    parameter int NUM_CH         = 1,
    parameter int ORDER_W        = 64,
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int HALT_REPEAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     commit_valid,
    input  logic [32*NUM_CH-1:0]  commit_pc,
    input  logic [32*NUM_CH-1:0]  commit_next_pc,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_resp,
    output logic [ORDER_W-1:0]    order,
    output logic                  halt,
    output logic                  timeout,
    output logic [3:0]            errcode,
    output logic                  done
);
    localparam int              CNT_W      = $clog2(NUM_CH + 1);
    localparam int              WD_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT   = WD_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]      LOOP_LIMIT = 4'(HALT_REPEAT);

    typedef enum logic [1:0] {RUN, HALTED, TIMED_OUT, ERROR} state_t;

    state_t             state_q, state_d;
    logic [ORDER_W-1:0] order_q, order_d;
    logic [3:0]         loop_q, loop_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [3:0]         err_q, err_d;
    logic               halt_q, halt_d;
    logic               timeout_q, timeout_d;
    logic               done_q, done_d;

    logic [NUM_CH-1:0]  self_loop;
    logic [CNT_W-1:0]   commit_cnt;
    logic               cnt_stop;
    logic               gap;
    logic               any_commit;
    logic               any_loop;
    logic [2:0]         mem_err;

    // Retirement stops counting after the oldest self-looping channel.
    always_comb begin
        self_loop  = '0;
        commit_cnt = '0;
        cnt_stop   = 1'b0;
        gap        = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            self_loop[i] = commit_valid[i] && (commit_pc[32*i +: 32] == commit_next_pc[32*i +: 32]);
            if (!cnt_stop && commit_valid[i]) begin
                commit_cnt = commit_cnt + CNT_W'(1);
            end
            if (self_loop[i]) begin
                cnt_stop = 1'b1;
            end
        end
        for (int i = 1; i < NUM_CH; i++) begin
            if (commit_valid[i] && !commit_valid[i-1]) begin
                gap = 1'b1;
            end
        end
    end

    assign any_commit = |commit_valid;
    assign any_loop   = |self_loop;

`ifdef COMMIT_MONITOR_MEMCHK_EN
    logic pend_q, pend_d;
    logic pend_wr_q, pend_wr_d;
    logic mem_req;
    logic orig_req;

    // A request answered in the same cycle it is issued never becomes pending.
    always_comb begin
        mem_req    = mem_read | mem_write;
        orig_req   = pend_wr_q ? mem_write : mem_read;
        pend_d     = pend_q;
        pend_wr_d  = pend_wr_q;
        mem_err    = '0;
        mem_err[0] = mem_read & mem_write;
        if (!pend_q) begin
            if (mem_req && !mem_resp) begin
                pend_d    = 1'b1;
                pend_wr_d = mem_write;
            end else if (mem_resp && !mem_req) begin
                mem_err[1] = 1'b1;
            end
        end else begin
            if (mem_resp) begin
                pend_d = 1'b0;
            end else if (!orig_req) begin
                mem_err[2] = 1'b1;
                pend_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= 1'b0;
            pend_wr_q <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end
`else
    logic mem_unused;
    assign mem_unused = mem_read ^ mem_write ^ mem_resp;
    assign mem_err    = 3'b000;
`endif

    always_comb begin
        state_d = state_q;
        order_d = order_q;
        loop_d  = loop_q;
        wd_d    = wd_q;
        err_d   = err_q | {gap, mem_err};
        if (state_q == RUN) begin
            if (!gap) begin
                order_d = order_q + ORDER_W'(commit_cnt);
            end
            if (any_loop) begin
                loop_d = loop_q + 4'd1;
            end else if (any_commit) begin
                loop_d = '0;
            end
            wd_d = any_commit ? '0 : wd_q + WD_W'(1);
            if (err_d != 4'd0) begin
                state_d = ERROR;
            end else if (loop_d >= LOOP_LIMIT) begin
                state_d = HALTED;
            end else if (wd_d >= WD_LIMIT) begin
                state_d = TIMED_OUT;
            end
        end
        halt_d    = (state_d == HALTED);
        timeout_d = (state_d == TIMED_OUT);
        done_d    = halt_d | timeout_d | (err_d != 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            order_q   <= '0;
            loop_q    <= '0;
            wd_q      <= '0;
            err_q     <= '0;
            halt_q    <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            order_q   <= order_d;
            loop_q    <= loop_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            halt_q    <= halt_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
        end
    end

    assign order   = order_q;
    assign halt    = halt_q;
    assign timeout = timeout_q;
    assign errcode = err_q;
    assign done    = done_q;
endmodule

// File: tb/tb_commit_monitor.sv
// Bench for commit_monitor: three configurations (1, 2 and 3 channels) driven by a vector table
// and directed multi-cycle sequences.
module tb_commit_monitor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef COMMIT_MONITOR_MEMCHK_EN
    localparam bit MEMCHK = 1'b1;
`else
    localparam bit MEMCHK = 1'b0;
`endif

    // u1: NUM_CH=1, ORDER_W=4, TIMEOUT=10, HALT_REPEAT=1
    logic        rst1 = 1'b1;
    logic [0:0]  v1 = '0;
    logic [31:0] pc1 = '0, npc1 = '0;
    logic        rd1 = 1'b0, wr1 = 1'b0, rsp1 = 1'b0;
    logic [3:0]  order1;
    logic        halt1, to1, done1;
    logic [3:0]  err1;

    // u2: NUM_CH=2, ORDER_W=8, TIMEOUT=10, HALT_REPEAT=1
    logic        rst2 = 1'b1;
    logic [1:0]  v2 = '0;
    logic [63:0] pc2 = 64'h0000_0204_0000_0100, npc2 = '0;
    logic [7:0]  order2;
    logic        halt2, to2, done2;
    logic [3:0]  err2;

    // u3: NUM_CH=3, ORDER_W=8, TIMEOUT=20, HALT_REPEAT=3
    logic        rst3 = 1'b1;
    logic [2:0]  v3 = '0;
    logic [95:0] pc3 = 96'h0000_0300_0000_0200_0000_0100, npc3 = '0;
    logic [7:0]  order3;
    logic        halt3, to3, done3;
    logic [3:0]  err3;

    commit_monitor #(.NUM_CH(1), .ORDER_W(4), .TIMEOUT_CYCLES(10), .HALT_REPEAT(1)) u1 (
        .clk(clk), .rst(rst1), .commit_valid(v1), .commit_pc(pc1), .commit_next_pc(npc1),
        .mem_read(rd1), .mem_write(wr1), .mem_resp(rsp1),
        .order(order1), .halt(halt1), .timeout(to1), .errcode(err1), .done(done1));

    commit_monitor #(.NUM_CH(2), .ORDER_W(8), .TIMEOUT_CYCLES(10), .HALT_REPEAT(1)) u2 (
        .clk(clk), .rst(rst2), .commit_valid(v2), .commit_pc(pc2), .commit_next_pc(npc2),
        .mem_read(1'b0), .mem_write(1'b0), .mem_resp(1'b0),
        .order(order2), .halt(halt2), .timeout(to2), .errcode(err2), .done(done2));

    commit_monitor #(.NUM_CH(3), .ORDER_W(8), .TIMEOUT_CYCLES(20), .HALT_REPEAT(3)) u3 (
        .clk(clk), .rst(rst3), .commit_valid(v3), .commit_pc(pc3), .commit_next_pc(npc3),
        .mem_read(1'b0), .mem_write(1'b0), .mem_resp(1'b0),
        .order(order3), .halt(halt3), .timeout(to3), .errcode(err3), .done(done3));

    typedef struct packed {
        logic       rst;
        logic [1:0] v;
        logic [1:0] lp;
        logic [7:0] order;
        logic       halt;
        logic       to;
        logic [3:0] err;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [1:0] v, input logic [1:0] lp,
                       input logic [7:0] o, input logic h, input logic t,
                       input logic [3:0] e, input logic d);
        vec_t row;
        row.rst = r; row.v = v; row.lp = lp; row.order = o;
        row.halt = h; row.to = t; row.err = e; row.done = d;
        vecs.push_back(row);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [3:0] o, input logic h, input logic t,
                        input logic [3:0] e, input logic d);
        chk($sformatf("%s.order", tag),   32'(order1), 32'(o));
        chk($sformatf("%s.halt", tag),    32'(halt1),  32'(h));
        chk($sformatf("%s.timeout", tag), 32'(to1),    32'(t));
        chk($sformatf("%s.errcode", tag), 32'(err1),   32'(e));
        chk($sformatf("%s.done", tag),    32'(done1),  32'(d));
    endtask

    task automatic chk3(input string tag, input logic [7:0] o, input logic h, input logic d);
        chk($sformatf("%s.order", tag), 32'(order3), 32'(o));
        chk($sformatf("%s.halt", tag),  32'(halt3),  32'(h));
        chk($sformatf("%s.done", tag),  32'(done3),  32'(d));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic c1(input logic v, input logic [31:0] pc, input logic [31:0] npc);
        v1 = v; pc1 = pc; npc1 = npc;
        tick();
    endtask

    task automatic c3(input logic [2:0] v, input logic [2:0] lp);
        v3 = v;
        for (int i = 0; i < 3; i++) begin
            npc3[32*i +: 32] = lp[i] ? pc3[32*i +: 32] : pc3[32*i +: 32] + 32'd4;
        end
        tick();
    endtask

    initial begin
        // rst, valid, self-loop, order, halt, timeout, errcode, done
        add(1'b1, 2'b00, 2'b00, 8'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        add(1'b0, 2'b11, 2'b00, 8'd2, 1'b0, 1'b0, 4'h0, 1'b0);
        add(1'b0, 2'b01, 2'b00, 8'd3, 1'b0, 1'b0, 4'h0, 1'b0);
        add(1'b0, 2'b00, 2'b00, 8'd3, 1'b0, 1'b0, 4'h0, 1'b0);
        add(1'b0, 2'b11, 2'b00, 8'd5, 1'b0, 1'b0, 4'h0, 1'b0);
        add(1'b0, 2'b11, 2'b10, 8'd7, 1'b1, 1'b0, 4'h0, 1'b1);
        add(1'b0, 2'b11, 2'b00, 8'd7, 1'b1, 1'b0, 4'h0, 1'b1);
        add(1'b0, 2'b10, 2'b00, 8'd7, 1'b1, 1'b0, 4'h8, 1'b1);
        add(1'b1, 2'b11, 2'b11, 8'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        add(1'b0, 2'b11, 2'b01, 8'd1, 1'b1, 1'b0, 4'h0, 1'b1);
        add(1'b1, 2'b00, 2'b00, 8'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        add(1'b0, 2'b10, 2'b00, 8'd0, 1'b0, 1'b0, 4'h8, 1'b1);
        add(1'b0, 2'b01, 2'b01, 8'd0, 1'b0, 1'b0, 4'h8, 1'b1);
        add(1'b1, 2'b00, 2'b00, 8'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        add(1'b0, 2'b01, 2'b00, 8'd1, 1'b0, 1'b0, 4'h0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            add(1'b0, 2'b00, 2'b00, 8'd1, 1'b0, 1'b0, 4'h0, 1'b0);
        end
        add(1'b0, 2'b00, 2'b00, 8'd1, 1'b0, 1'b1, 4'h0, 1'b1);
        add(1'b0, 2'b11, 2'b00, 8'd1, 1'b0, 1'b1, 4'h0, 1'b1);
        add(1'b0, 2'b10, 2'b00, 8'd1, 1'b0, 1'b1, 4'h8, 1'b1);

        #1;
        for (int k = 0; k < vecs.size(); k++) begin
            rst2 = vecs[k].rst;
            v2   = vecs[k].v;
            npc2[31:0]  = vecs[k].lp[0] ? pc2[31:0]  : pc2[31:0]  + 32'd4;
            npc2[63:32] = vecs[k].lp[1] ? pc2[63:32] : pc2[63:32] + 32'd4;
            tick();
            chk($sformatf("vec%0d.order", k),   32'(order2), 32'(vecs[k].order));
            chk($sformatf("vec%0d.halt", k),    32'(halt2),  32'(vecs[k].halt));
            chk($sformatf("vec%0d.timeout", k), 32'(to2),    32'(vecs[k].to));
            chk($sformatf("vec%0d.errcode", k), 32'(err2),   32'(vecs[k].err));
            chk($sformatf("vec%0d.done", k),    32'(done2),  32'(vecs[k].done));
        end
        v2 = 2'b00;

        // Five distinct commits then a self-loop at 0x60
        rst1 = 1'b1; tick();
        chk1("u1_reset", 4'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        rst1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c1(1'b1, 32'h40 + 32'(4*i), 32'h44 + 32'(4*i));
        end
        chk1("u1_five", 4'd5, 1'b0, 1'b0, 4'h0, 1'b0);
        c1(1'b1, 32'h60, 32'h60);
        chk1("u1_halt", 4'd6, 1'b1, 1'b0, 4'h0, 1'b1);

        // Watchdog restarted by a commit on idle cycle 9
        rst1 = 1'b1; c1(1'b0, 32'h0, 32'h0);
        rst1 = 1'b0;
        c1(1'b1, 32'h10, 32'h14);
        v1 = 1'b0;
        repeat (8) tick();
        c1(1'b1, 32'h20, 32'h24);
        v1 = 1'b0;
        repeat (9) tick();
        chk1("u1_wd_restart", 4'd2, 1'b0, 1'b0, 4'h0, 1'b0);
        tick();
        chk1("u1_wd_expire", 4'd2, 1'b0, 1'b1, 4'h0, 1'b1);

        // 4-bit order wraps, then reset mid-run with live inputs
        rst1 = 1'b1; c1(1'b0, 32'h0, 32'h0);
        rst1 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            c1(1'b1, 32'h80 + 32'(8*i), 32'h84 + 32'(8*i));
        end
        chk1("u1_wrap", 4'd1, 1'b0, 1'b0, 4'h0, 1'b0);
        rst1 = 1'b1; rd1 = 1'b1; wr1 = 1'b1;
        c1(1'b1, 32'h90, 32'h90);
        chk1("u1_midrst", 4'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        rst1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; v1 = 1'b0;

        // Memory handshake checks
        rd1 = 1'b1; wr1 = 1'b1; tick();
        rd1 = 1'b0; wr1 = 1'b0;
        chk1("mem_rw", 4'd0, 1'b0, 1'b0, MEMCHK ? 4'h1 : 4'h0, MEMCHK);
        rst1 = 1'b1; tick(); rst1 = 1'b0;
        rd1 = 1'b1; tick();
        chk1("mem_pend1", 4'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        tick();
        chk1("mem_pend2", 4'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        rd1 = 1'b0; tick();
        chk1("mem_drop", 4'd0, 1'b0, 1'b0, MEMCHK ? 4'h4 : 4'h0, MEMCHK);
        rst1 = 1'b1; tick(); rst1 = 1'b0;
        rsp1 = 1'b1; tick(); rsp1 = 1'b0;
        chk1("mem_orphan", 4'd0, 1'b0, 1'b0, MEMCHK ? 4'h2 : 4'h0, MEMCHK);
        rst1 = 1'b1; tick(); rst1 = 1'b0;
        wr1 = 1'b1; tick(); tick();
        wr1 = 1'b0; rsp1 = 1'b1; tick();
        rsp1 = 1'b0; tick();
        chk1("mem_good", 4'd0, 1'b0, 1'b0, 4'h0, 1'b0);

        // Loop counter holds on idle, clears on non-loop commits, halts on third loop
        rst3 = 1'b1; c3(3'b000, 3'b000);
        rst3 = 1'b0;
        c3(3'b111, 3'b010);
        chk3("u3_loop1", 8'd2, 1'b0, 1'b0);
        c3(3'b000, 3'b000);
        c3(3'b001, 3'b000);
        chk3("u3_clear", 8'd3, 1'b0, 1'b0);
        c3(3'b111, 3'b100);
        c3(3'b111, 3'b011);
        chk3("u3_loop2", 8'd7, 1'b0, 1'b0);
        c3(3'b111, 3'b100);
        chk3("u3_halt", 8'd10, 1'b1, 1'b1);
        chk("u3_timeout", 32'(to3), 32'd0);
        chk("u3_errcode", 32'(err3), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/commit_monitor.md
COMMIT_MONITOR -- requirements
Module: commit_monitor

Interface
REQ-001 Parameter NUM_CH, default 1, number of commit channels (1..4); channel 0 is oldest in program order.
REQ-002 Parameter ORDER_W, default 64, width of the retired-instruction counter.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000000, commit-free cycles before watchdog expiry (>=1).
REQ-004 Parameter HALT_REPEAT, default 1, consecutive self-loop commits required to declare halt (1..15).
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 commit_valid  in  NUM_CH  per-channel commit strobe.
REQ-008 commit_pc  in  32*NUM_CH  PC of committing instruction, channel i at bits [32i+31:32i].
REQ-009 commit_next_pc  in  32*NUM_CH  next PC written by that instruction.
REQ-010 mem_read, mem_write, mem_resp  in  1 each  physical memory handshake observed.
REQ-011 order  out  ORDER_W  count of retired instructions.
REQ-012 halt, timeout  out  1 each  sticky terminal flags.
REQ-013 errcode  out  4  sticky error flags: [0] simultaneous read+write, [1] resp with no request, [2] request dropped before resp, [3] commit_valid[i] set with commit_valid[i-1] clear.
REQ-014 done  out  1  halt | timeout | (errcode != 0).

Function
REQ-015 FSM states RUN, HALTED, TIMED_OUT, ERROR; RUN is the only non-terminal state; terminal states held until rst.
REQ-016 All outputs registered; every event is reflected on outputs on the cycle after the sampling edge.
REQ-017 A channel self-loops when commit_valid[i] and commit_pc[i] == commit_next_pc[i].
REQ-018 In RUN, order increments by the number of valid channels up to and including the lowest-index self-looping channel (all valid channels if none); higher-index channels in that cycle are ignored.
REQ-019 order wraps modulo 2^ORDER_W without flag.
REQ-020 Loop counter increments on a cycle containing a self-loop, clears on a cycle with commits but no self-loop, holds on cycles with no commits; reaching HALT_REPEAT -> HALTED.
REQ-021 Watchdog counter clears on any cycle with a commit, else increments; reaching TIMEOUT_CYCLES -> TIMED_OUT.
REQ-022 Memory tracker IDLE/PENDING: request (read or write) in IDLE -> PENDING; resp in PENDING -> IDLE; request and resp in same cycle from PENDING -> IDLE.
REQ-023 errcode[1] sets on mem_resp in IDLE without request; errcode[2] sets when PENDING and neither the original request nor resp is asserted; errcode[0] sets on mem_read & mem_write in any state.
REQ-024 errcode[3] sets on any commit channel gap; that cycle's commits are not counted.
REQ-025 Any errcode bit set -> ERROR; same-cycle priority ERROR > HALTED > TIMED_OUT.
REQ-026 In any terminal state order, loop and watchdog counters freeze; errcode continues to accumulate.

Reset
REQ-027 rst forces RUN, order=0, halt=0, timeout=0, errcode=0, done=0, loop, watchdog counters and memory tracker to zero/IDLE on the next edge.
REQ-028 rst asserted mid-operation (including PENDING or terminal state) discards all history; inputs in the rst cycle are ignored.

Configuration
REQ-029 Macro COMMIT_MONITOR_MEMCHK_EN defined: memory tracker and errcode[2:0] operate per REQ-022/023.
REQ-030 Macro undefined: tracker omitted, errcode[2:0] tied 0, mem_read/mem_write/mem_resp unused; errcode[3] and all other behaviour unchanged.

Verification
REQ-031 NUM_CH=1: 5 commits with distinct PCs then commit pc=next_pc=0x60 -> order=6, halt=1 one cycle later, done=1.
REQ-032 NUM_CH=2, HALT_REPEAT=1: valid=2'b11, channel 0 self-loops -> order +1 only, halt=1.
REQ-033 TIMEOUT_CYCLES=10: one commit then 10 idle cycles -> timeout=1 on cycle 11, order frozen at 1; commit on cycle 9 instead -> no timeout.
REQ-034 MEMCHK_EN: mem_read=1 and mem_write=1 same cycle -> errcode=4'b0001, done=1; separately read dropped after 2 cycles without resp -> errcode[2]=1.
REQ-035 ORDER_W=4: 17 non-loop commits -> order=1; then rst mid-run -> all outputs 0 next cycle.
REQ-036 NUM_CH=2: valid=2'b10 -> errcode[3]=1, order unchanged, state ERROR; simultaneous self-loop on later cycle -> halt stays 0.
